regfile_read_stage: RTL and testbench
=====================================

Name: regfile_read_stage

Overview:
- Read side of the Y86-style register file. Takes a decoded instruction's srcA/srcB, selects operand values, and loads the D->E pipeline register.
- Operand sources are the register file outputs r0-r5 or forwarded in-flight results.
- Detects load-use hazards, holds upstream, and inserts a bubble.
- Sits between fetch/decode and execute; the register file writer sits downstream at writeback.

Parameters:
- W, 32, data width of register values and valC.
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears the E register.
- in_valid  input  1  decode slot holds an instruction.
- in_ready  output  1  combinational; instruction accepted this cycle.
- icode  input  4  instruction code.
- srcA, srcB  input  4 each  source register IDs.
- dstE, dstM  input  4 each  destination IDs passed through.
- valC  input  W  constant passed through.
- r0..r5  input  W each  register file contents.
- e_dstE / e_valE  input  4 / W  execute-stage ALU result.
- M_dstM / m_valM  input  4 / W  memory-stage load result.
- M_dstE / M_valE  input  4 / W  memory-stage ALU result.
- W_dstM / W_valM, W_dstE / W_valE  input  4 / W each  writeback results.
- stall_in  input  1  downstream freeze.
- E_valid  output  1  registered.
- E_icode  output  4  registered.
- E_valA, E_valB  output  W each  registered.
- E_valC  output  W  registered.
- E_srcA, E_srcB, E_dstE, E_dstM  output  4 each  registered.
- load_use_stall  output  1  combinational hazard indicator.

Behaviour:
- Reset (async, any time, including mid-stall): E_valid=0, E_icode=4'h1 (NOP), E_srcA/srcB/dstE/dstM=RNONE, E_valA/valB/valC=0.
- Register read: IDs 0-5 map to r0-r5. RNONE and IDs 6-14 read as 0.
- Forward priority for srcX != RNONE (first match wins): e_dstE -> e_valE; M_dstM -> m_valM; M_dstE -> M_valE; W_dstM -> W_valM; W_dstE -> W_valE; then the register file.
- W_dstM beats W_dstE, matching the register file's rule that the M-port write wins on an equal destination.
- Forward IDs equal to RNONE never match.
- load_use_stall = in_valid & E_valid & (E_dstM != RNONE) & (E_dstM == srcA | E_dstM == srcB). A source equal to RNONE never matches.
- in_ready = !stall_in & !load_use_stall.
- Per rising edge, in priority order:
  - stall_in=1: E register holds all fields.
  - load_use_stall=1: bubble is loaded (E_valid=0, NOP, IDs RNONE, data 0). The instruction remains upstream and is re-presented.
  - in_valid=1: E register loads the decoded fields and selected values; E_valid=1.
  - Otherwise: bubble.
- Latency: one cycle from acceptance to E_* outputs.
- Back-to-back accepts are allowed at one per cycle.
- The load-use stall lasts exactly one cycle. The next cycle forwards via M_dstM/m_valM.
- srcA==srcB is legal; both operands get the same value.

Optional Feature:
- Macro: REGREAD_FORWARD_EN.
- Defined: forwarding and the single load-use stall as described above.
- Undefined: no forwarding; operands come only from the register file.
- Undefined: load_use_stall asserts whenever in_valid and any non-RNONE src equals any of E_dstE (if E_valid), E_dstM (if E_valid), M_dstE, M_dstM, W_dstE or W_dstM.
- Undefined: the stall persists until no match remains, with a bubble each stalled cycle.

Test Plan:
- Reset asserted mid-cycle with E_valid=1 -> E_valid=0 and E_icode=1 immediately, without waiting for an edge; all IDs = 4'hF.
- No hazards: r2=32'h11, r3=32'h22, srcA=2, srcB=3, valC=5 -> next edge E_valA=0x11, E_valB=0x22, E_valC=5, E_valid=1.
- Forward priority: srcA=4, e_dstE=4 with e_valE=0xAA, M_dstE=4 with M_valE=0xBB, r4=0xCC -> E_valA=0xAA. With e_dstE=RNONE -> 0xBB.
- Writeback tie: srcB=1, W_dstE=1 with W_valE=0x10, W_dstM=1 with W_valM=0x20 -> E_valB=0x20.
- Load-use: E_dstM=3, E_valid=1, in_valid, srcB=3 -> in_ready=0 and a bubble for one cycle. Next cycle M_dstM=3 with m_valM=0x55 -> E_valB=0x55.
- stall_in=1 together with a load-use hazard -> E register unchanged and in_ready=0. Release -> bubble, then normal accept.

Source files
------------

// File: rtl/regfile_read_stage_if.sv
// regfile_read_stage_if: decode-slot handshake, operand sources and the D->E register outputs.
// Latency: none; this is a bundle of wires.
// Backpressure: in_ready/load_use_stall travel upstream and stall_in comes in from downstream.
interface regfile_read_stage_if #(
  parameter int W = 32
);
  // Decode slot
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   srcA;
  logic [3:0]   srcB;
  logic [3:0]   dstE;
  logic [3:0]   dstM;
  logic [W-1:0] valC;
  // Register file contents
  logic [W-1:0] r0;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic [W-1:0] r3;
  logic [W-1:0] r4;
  logic [W-1:0] r5;
  // In-flight results from later stages
  logic [3:0]   e_dstE;
  logic [W-1:0] e_valE;
  logic [3:0]   M_dstM;
  logic [W-1:0] m_valM;
  logic [3:0]   M_dstE;
  logic [W-1:0] M_valE;
  logic [3:0]   W_dstM;
  logic [W-1:0] W_valM;
  logic [3:0]   W_dstE;
  logic [W-1:0] W_valE;
  // Downstream freeze
  logic         stall_in;
  // D->E pipeline register
  logic         E_valid;
  logic [3:0]   E_icode;
  logic [W-1:0] E_valA;
  logic [W-1:0] E_valB;
  logic [W-1:0] E_valC;
  logic [3:0]   E_srcA;
  logic [3:0]   E_srcB;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic         load_use_stall;

  modport master (
    output in_valid, icode, srcA, srcB, dstE, dstM, valC,
    output r0, r1, r2, r3, r4, r5,
    output e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    output W_dstM, W_valM, W_dstE, W_valE, stall_in,
    input  in_ready, load_use_stall,
    input  E_valid, E_icode, E_valA, E_valB, E_valC, E_srcA, E_srcB, E_dstE, E_dstM
  );

  modport slave (
    input  in_valid, icode, srcA, srcB, dstE, dstM, valC,
    input  r0, r1, r2, r3, r4, r5,
    input  e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    input  W_dstM, W_valM, W_dstE, W_valE, stall_in,
    output in_ready, load_use_stall,
    output E_valid, E_icode, E_valA, E_valB, E_valC, E_srcA, E_srcB, E_dstE, E_dstM
  );
endinterface

// File: rtl/regfile_read_stage.sv
// regfile_read_stage: selects operands (register file or forwarded results) and loads the D->E register.
// Latency: one cycle from acceptance to E_*; in_ready and load_use_stall are combinational.
// Backpressure: stall_in freezes E; a hazard drops in_ready and loads a bubble so decode re-presents.
// Build option REGREAD_FORWARD_EN: when defined, forwarding plus a single-cycle load-use stall;
// when undefined, operands come only from the register file and the stage stalls while any
// in-flight write still targets a source register.
module regfile_read_stage #(
  parameter int         W     = 32,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic clock,
  input logic reset,
  regfile_read_stage_if.slave bus
);
  localparam logic [3:0] INOP = 4'h1;

  typedef struct packed {
    logic         valid;
    logic [3:0]   icode;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
  } ereg_t;

  localparam ereg_t BUBBLE = '{valid: 1'b0, icode: INOP, srcA: RNONE, srcB: RNONE,
                               dstE: RNONE, dstM: RNONE, valA: '0, valB: '0, valC: '0};

  ereg_t        e_q;
  ereg_t        e_d;
  logic [W-1:0] rf [0:7];
  logic [W-1:0] rf_a;
  logic [W-1:0] rf_b;
  logic [W-1:0] val_a;
  logic [W-1:0] val_b;
  logic         lus;

  // A source matches a destination only when it names a real register.
  function automatic logic hit(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

  // IDs 6-7 read as zero; IDs 8-15 are rejected before indexing.
  assign rf[0] = bus.r0;
  assign rf[1] = bus.r1;
  assign rf[2] = bus.r2;
  assign rf[3] = bus.r3;
  assign rf[4] = bus.r4;
  assign rf[5] = bus.r5;
  assign rf[6] = '0;
  assign rf[7] = '0;

  assign rf_a = (bus.srcA <= 4'd5) ? rf[bus.srcA[2:0]] : '0;
  assign rf_b = (bus.srcB <= 4'd5) ? rf[bus.srcB[2:0]] : '0;

`ifdef REGREAD_FORWARD_EN
  // Slot 0 is the highest priority: e_dstE, M_dstM, M_dstE, W_dstM, W_dstE.
  logic [5*4-1:0] fwd_ids;
  logic [5*W-1:0] fwd_vals;

  assign fwd_ids  = {bus.W_dstE, bus.W_dstM, bus.M_dstE, bus.M_dstM, bus.e_dstE};
  assign fwd_vals = {bus.W_valE, bus.W_valM, bus.M_valE, bus.m_valM, bus.e_valE};

  // Walk from lowest to highest priority so the first match in priority order wins.
  function automatic logic [W-1:0] pick(input logic [3:0] src, input logic [W-1:0] rfv,
                                        input logic [5*4-1:0] ids, input logic [5*W-1:0] vals);
    logic [W-1:0] r;
    r = rfv;
    for (int i = 4; i >= 0; i--) begin
      if (hit(src, ids[i*4 +: 4])) r = vals[i*W +: W];
    end
    return r;
  endfunction

  assign val_a = pick(bus.srcA, rf_a, fwd_ids, fwd_vals);
  assign val_b = pick(bus.srcB, rf_b, fwd_ids, fwd_vals);

  // Only a load sitting in E cannot be forwarded yet; one bubble lets it reach M.
  assign lus = bus.in_valid && e_q.valid && (e_q.dstM != RNONE) &&
               ((e_q.dstM == bus.srcA) || (e_q.dstM == bus.srcB));
`else
  logic [6*4-1:0] pend_ids;
  logic           unused_fwd;

  // Every pending writer, with E slots masked by E_valid.
  assign pend_ids = {bus.W_dstM, bus.W_dstE, bus.M_dstM, bus.M_dstE,
                     e_q.valid ? e_q.dstM : RNONE, e_q.valid ? e_q.dstE : RNONE};

  function automatic logic any_hit(input logic [3:0] src, input logic [6*4-1:0] ids);
    logic h;
    h = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (hit(src, ids[i*4 +: 4])) h = 1'b1;
    end
    return h;
  endfunction

  assign val_a = rf_a;
  assign val_b = rf_b;
  assign lus   = bus.in_valid && (any_hit(bus.srcA, pend_ids) || any_hit(bus.srcB, pend_ids));

  // Forwarded values have no consumer without the bypass network.
  assign unused_fwd = ^{bus.e_dstE, bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
`endif

  assign bus.load_use_stall = lus;
  assign bus.in_ready       = !bus.stall_in && !lus;

  // Next E contents: freeze, bubble on hazard, load on valid, bubble when idle.
  always_comb begin
    e_d = e_q;
    if (bus.stall_in) begin
      e_d = e_q;
    end else if (lus) begin
      e_d = BUBBLE;
    end else if (bus.in_valid) begin
      e_d.valid = 1'b1;
      e_d.icode = bus.icode;
      e_d.srcA  = bus.srcA;
      e_d.srcB  = bus.srcB;
      e_d.dstE  = bus.dstE;
      e_d.dstM  = bus.dstM;
      e_d.valA  = val_a;
      e_d.valB  = val_b;
      e_d.valC  = bus.valC;
    end else begin
      e_d = BUBBLE;
    end
  end

  // E register; reset loads a NOP bubble immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) e_q <= BUBBLE;
    else       e_q <= e_d;
  end

  assign bus.E_valid = e_q.valid;
  assign bus.E_icode = e_q.icode;
  assign bus.E_srcA  = e_q.srcA;
  assign bus.E_srcB  = e_q.srcB;
  assign bus.E_dstE  = e_q.dstE;
  assign bus.E_dstM  = e_q.dstM;
  assign bus.E_valA  = e_q.valA;
  assign bus.E_valB  = e_q.valB;
  assign bus.E_valC  = e_q.valC;
endmodule

// File: tb/tb_regfile_read_stage.sv
// tb_regfile_read_stage: scoreboard bench for the D->E read stage.
// Expected E contents are queued at the negedge that drives stimulus and checked 1ns after the edge.
// Mode-dependent expectations follow REGREAD_FORWARD_EN.
module tb_regfile_read_stage;
  localparam logic [3:0] RN = 4'hF;

  logic clock = 1'b0;
  logic reset = 1'b0;

  regfile_read_stage_if #(.W(32)) bus();

  regfile_read_stage #(.W(32), .RNONE(4'hF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [31:0] valA;
    logic [31:0] valB;
    logic [31:0] valC;
  } e_t;

  localparam e_t BUB = '{1'b0, 4'h1, RN, RN, RN, RN, 32'h0, 32'h0, 32'h0};

  e_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic e_t mk(input logic v, input logic [3:0] ic, input logic [3:0] sa,
                            input logic [3:0] sbb, input logic [3:0] de, input logic [3:0] dm,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    mk = '{v, ic, sa, sbb, de, dm, a, b, c};
  endfunction

  // Scoreboard: one queued entry per clock edge it was pushed for.
  always @(posedge clock) begin : mon
    e_t want;
    e_t got;
    #1;
    if (sb.size() > 0) begin
      want = sb.pop_front();
      got  = '{bus.E_valid, bus.E_icode, bus.E_srcA, bus.E_srcB, bus.E_dstE, bus.E_dstM,
               bus.E_valA, bus.E_valB, bus.E_valC};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL E_reg @%0t: got v=%b ic=%h sA=%h sB=%h dE=%h dM=%h A=%h B=%h C=%h, expected v=%b ic=%h sA=%h sB=%h dE=%h dM=%h A=%h B=%h C=%h",
                 $time, got.valid, got.icode, got.srcA, got.srcB, got.dstE, got.dstM,
                 got.valA, got.valB, got.valC, want.valid, want.icode, want.srcA, want.srcB,
                 want.dstE, want.dstM, want.valA, want.valB, want.valC);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic set_defaults();
    bus.in_valid = 1'b0; bus.icode = 4'h1; bus.srcA = RN; bus.srcB = RN;
    bus.dstE = RN; bus.dstM = RN; bus.valC = 32'h0;
    bus.r0 = 32'h100; bus.r1 = 32'h101; bus.r2 = 32'h102;
    bus.r3 = 32'h103; bus.r4 = 32'h104; bus.r5 = 32'h105;
    bus.e_dstE = RN; bus.e_valE = 32'hDEAD0001;
    bus.M_dstM = RN; bus.m_valM = 32'hDEAD0002;
    bus.M_dstE = RN; bus.M_valE = 32'hDEAD0003;
    bus.W_dstM = RN; bus.W_valM = 32'hDEAD0004;
    bus.W_dstE = RN; bus.W_valE = 32'hDEAD0005;
    bus.stall_in = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [3:0] ic, input logic [3:0] sa,
                       input logic [3:0] sbb, input logic [3:0] de, input logic [3:0] dm,
                       input logic [31:0] c);
    bus.in_valid = iv; bus.icode = ic; bus.srcA = sa; bus.srcB = sbb;
    bus.dstE = de; bus.dstM = dm; bus.valC = c;
  endtask

  task automatic test_reset();
    set_defaults();
    #1 reset = 1'b1;
    #11;
    n_cmp++;
    if (bus.E_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.E_valid); end
    n_cmp++;
    if (bus.E_icode !== 4'h1) begin n_bad++; $display("FAIL reset_icode: got %h expected 1", bus.E_icode); end
    n_cmp++;
    if ({bus.E_srcA, bus.E_srcB, bus.E_dstE, bus.E_dstM} !== 16'hFFFF) begin
      n_bad++; $display("FAIL reset_ids: got %h expected ffff", {bus.E_srcA, bus.E_srcB, bus.E_dstE, bus.E_dstM});
    end
    n_cmp++;
    if ({bus.E_valA, bus.E_valB, bus.E_valC} !== 96'h0) begin
      n_bad++; $display("FAIL reset_vals: got %h expected 0", {bus.E_valA, bus.E_valB, bus.E_valC});
    end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    drive(1'b1, 4'h2, 4'h0, 4'h1, 4'h2, RN, 32'h7);
    sb.push_back(mk(1'b1, 4'h2, 4'h0, 4'h1, 4'h2, RN, 32'h100, 32'h101, 32'h7));
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.E_valid !== 1'b0 || bus.E_icode !== 4'h1) begin
      n_bad++; $display("FAIL midcycle_reset: got valid=%b icode=%h expected valid=0 icode=1", bus.E_valid, bus.E_icode);
    end
    n_cmp++;
    if ({bus.E_srcA, bus.E_srcB, bus.E_dstE, bus.E_dstM} !== 16'hFFFF) begin
      n_bad++; $display("FAIL midcycle_reset_ids: got %h expected ffff", {bus.E_srcA, bus.E_srcB, bus.E_dstE, bus.E_dstM});
    end
    bus.in_valid = 1'b0;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    bus.r2 = 32'h11; bus.r3 = 32'h22;
    drive(1'b1, 4'h6, 4'h2, 4'h3, 4'h2, RN, 32'h5);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.load_use_stall !== 1'b0) begin
      n_bad++; $display("FAIL nohaz_ready: got ready=%b lus=%b expected ready=1 lus=0", bus.in_ready, bus.load_use_stall);
    end
    sb.push_back(mk(1'b1, 4'h6, 4'h2, 4'h3, 4'h2, RN, 32'h11, 32'h22, 32'h5));
    @(negedge clock);
    drive(1'b1, 4'h6, 4'h7, RN, RN, RN, 32'h9);
    sb.push_back(mk(1'b1, 4'h6, 4'h7, RN, RN, RN, 32'h0, 32'h0, 32'h9));
    @(negedge clock);
    drive(1'b1, 4'h6, 4'h5, 4'h5, RN, RN, 32'h3);
    sb.push_back(mk(1'b1, 4'h6, 4'h5, 4'h5, RN, RN, 32'h105, 32'h105, 32'h3));
    @(negedge clock);
    drive(1'b0, 4'h6, 4'h2, 4'h3, 4'h2, RN, 32'h1);
    sb.push_back(BUB);
  endtask

  task automatic test_forward();
    @(negedge clock);
    bus.r4 = 32'hCC;
    bus.e_dstE = 4'h4; bus.e_valE = 32'hAA;
    bus.M_dstE = 4'h4; bus.M_valE = 32'hBB;
    drive(1'b1, 4'h6, 4'h4, RN, RN, RN, 32'h0);
    #1;
    n_cmp++;
`ifdef REGREAD_FORWARD_EN
    if (bus.load_use_stall !== 1'b0) begin n_bad++; $display("FAIL fwd_lus: got %b expected 0", bus.load_use_stall); end
    sb.push_back(mk(1'b1, 4'h6, 4'h4, RN, RN, RN, 32'hAA, 32'h0, 32'h0));
`else
    if (bus.load_use_stall !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL nofwd_stall: got lus=%b ready=%b expected lus=1 ready=0", bus.load_use_stall, bus.in_ready);
    end
    sb.push_back(BUB);
`endif
    @(negedge clock);
    bus.e_dstE = RN;
`ifdef REGREAD_FORWARD_EN
    sb.push_back(mk(1'b1, 4'h6, 4'h4, RN, RN, RN, 32'hBB, 32'h0, 32'h0));
`else
    sb.push_back(BUB);
`endif
    @(negedge clock);
    bus.M_dstE = RN;
    sb.push_back(mk(1'b1, 4'h6, 4'h4, RN, RN, RN, 32'hCC, 32'h0, 32'h0));
  endtask

  task automatic test_wb_tie();
    @(negedge clock);
    bus.W_dstE = 4'h1; bus.W_valE = 32'h10;
    bus.W_dstM = 4'h1; bus.W_valM = 32'h20;
    drive(1'b1, 4'h6, RN, 4'h1, RN, RN, 32'h0);
`ifdef REGREAD_FORWARD_EN
    sb.push_back(mk(1'b1, 4'h6, RN, 4'h1, RN, RN, 32'h0, 32'h20, 32'h0));
    @(negedge clock);
    bus.W_dstE = RN; bus.W_dstM = RN;
    bus.in_valid = 1'b0;
    sb.push_back(BUB);
`else
    sb.push_back(BUB);
    @(negedge clock);
    bus.W_dstE = RN; bus.W_dstM = RN;
    sb.push_back(mk(1'b1, 4'h6, RN, 4'h1, RN, RN, 32'h0, 32'h101, 32'h0));
`endif
  endtask

  task automatic test_load_use();
    @(negedge clock);
    drive(1'b1, 4'h5, RN, RN, RN, 4'h3, 32'h8);
    sb.push_back(mk(1'b1, 4'h5, RN, RN, RN, 4'h3, 32'h0, 32'h0, 32'h8));
    @(negedge clock);
    drive(1'b1, 4'h6, RN, 4'h3, RN, RN, 32'h0);
    #1;
    n_cmp++;
    if (bus.load_use_stall !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL lu_detect: got lus=%b ready=%b expected lus=1 ready=0", bus.load_use_stall, bus.in_ready);
    end
    sb.push_back(BUB);
    @(negedge clock);
    bus.M_dstM = 4'h3; bus.m_valM = 32'h55;
    #1;
    n_cmp++;
`ifdef REGREAD_FORWARD_EN
    if (bus.load_use_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL lu_one_cycle: got lus=%b ready=%b expected lus=0 ready=1", bus.load_use_stall, bus.in_ready);
    end
    sb.push_back(mk(1'b1, 4'h6, RN, 4'h3, RN, RN, 32'h0, 32'h55, 32'h0));
    @(negedge clock);
    bus.M_dstM = RN;
    bus.in_valid = 1'b0;
    sb.push_back(BUB);
`else
    if (bus.load_use_stall !== 1'b1) begin
      n_bad++; $display("FAIL lu_persist_M: got lus=%b expected 1", bus.load_use_stall);
    end
    sb.push_back(BUB);
    @(negedge clock);
    bus.M_dstM = RN; bus.W_dstM = 4'h3;
    sb.push_back(BUB);
    @(negedge clock);
    bus.W_dstM = RN;
    sb.push_back(mk(1'b1, 4'h6, RN, 4'h3, RN, RN, 32'h0, 32'h22, 32'h0));
`endif
  endtask

  task automatic test_stall_in();
    e_t ld;
    ld = mk(1'b1, 4'h5, RN, RN, RN, 4'h3, 32'h0, 32'h0, 32'h8);
    @(negedge clock);
    drive(1'b1, 4'h5, RN, RN, RN, 4'h3, 32'h8);
    sb.push_back(ld);
    @(negedge clock);
    bus.stall_in = 1'b1;
    drive(1'b1, 4'h6, RN, 4'h3, RN, RN, 32'h0);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.load_use_stall !== 1'b1) begin
      n_bad++; $display("FAIL stall_hold_ready: got ready=%b lus=%b expected ready=0 lus=1", bus.in_ready, bus.load_use_stall);
    end
    sb.push_back(ld);
    @(negedge clock);
    bus.stall_in = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_release_ready: got %b expected 0", bus.in_ready); end
    sb.push_back(BUB);
    @(negedge clock);
`ifdef REGREAD_FORWARD_EN
    bus.M_dstM = 4'h3; bus.m_valM = 32'h66;
    sb.push_back(mk(1'b1, 4'h6, RN, 4'h3, RN, RN, 32'h0, 32'h66, 32'h0));
`else
    sb.push_back(mk(1'b1, 4'h6, RN, 4'h3, RN, RN, 32'h0, 32'h22, 32'h0));
`endif
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_accept_ready: got %b expected 1", bus.in_ready); end
    @(negedge clock);
    bus.M_dstM = RN;
    bus.in_valid = 1'b0;
    sb.push_back(BUB);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_forward();
    test_wb_tie();
    test_load_use();
    test_stall_in();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
